// File: rtl/oci_dct_trace_capture.sv
// -----------------------------------------------------------------------------
// oci_dct_trace_capture
//
// Data-trace capture buffer on the OCI debug path. DCT trace words from the
// core are queued in a DEPTH-entry show-ahead FIFO and drained by a
// ready/valid reader. A small FSM gates capture and, once an end-of-test
// request has fully flushed the FIFO, reports a sticky test-has-ended status.
//
// Optional feature (macro OCI_DCT_TIMESTAMP_EN): a free-running TS_W-bit cycle
// counter is stored alongside every accepted word and rd_data becomes
// {timestamp, trace_data}. With the macro undefined there is no counter and
// rd_data is DATA_W bits wide.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   arm            pulse: start / restart capture
//   trace_valid    trace word present this cycle
//   trace_data     trace word
//   test_ending    pulse: stop capture and flush
//   rd_ready       reader accepts rd_data
//   rd_valid       FIFO non-empty
//   rd_data        head entry (show-ahead), holds last value when empty
//   dct_count      occupancy, 0..DEPTH
//   overflow       sticky: at least one word dropped
//   drop_count     dropped words, saturating at 16'hFFFF
//   test_has_ended sticky: flush complete
//   state          FSM state (IDLE=0, CAPTURE=1, DRAIN=2, ENDED=3)
// -----------------------------------------------------------------------------
module oci_dct_trace_capture #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trace_valid,
  input  logic [DATA_W-1:0] trace_data,
  input  logic              test_ending,
  input  logic              rd_ready,
  output logic              rd_valid,
`ifdef OCI_DCT_TIMESTAMP_EN
  output logic [DATA_W+TS_W-1:0] rd_data,
`else
  output logic [DATA_W-1:0] rd_data,
`endif
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic              test_has_ended,
  output logic [1:0]        state
);

`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int OUT_W = DATA_W + TS_W;
`else
  localparam int OUT_W = DATA_W;
`endif
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_ENDED   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [OUT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [OUT_W-1:0]  r_rd_data;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic              w_wr_allowed;
  logic              w_clear_status;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;
  logic [OUT_W-1:0]  w_wdata;
  logic [PTR_W-1:0]  w_rd_ptr_inc;
  logic              w_head_load;
  logic [OUT_W-1:0]  w_head_next;

  // ---------------------------------------------------------------------------
  // Write payload (optionally timestamped)
  // ---------------------------------------------------------------------------
`ifdef OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts <= '0;
    else          r_ts <= r_ts + TS_W'(1);
  end

  assign w_wdata = {r_ts, trace_data};
`else
  assign w_wdata = trace_data;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM: next-state logic. test_ending outranks arm wherever both matter.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (test_ending)  w_state_next = S_DRAIN;
        else if (arm)     w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (test_ending)  w_state_next = S_DRAIN;
      end
      // Registered occupancy is checked, so DRAIN always lasts >= 1 cycle.
      S_DRAIN: begin
        if (w_empty)      w_state_next = S_ENDED;
      end
      S_ENDED: begin
        if (arm)          w_state_next = S_CAPTURE;
      end
      default:            w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_wr_allowed   = 1'b0;
    w_clear_status = 1'b0;
    test_has_ended = 1'b0;
    unique case (r_state)
      S_CAPTURE: w_wr_allowed = 1'b1;
      S_ENDED: begin
        test_has_ended = 1'b1;
        w_clear_status = arm;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_pop        = ~w_empty & rd_ready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign w_wr         = w_wr_allowed & trace_valid & (~w_full | w_pop);
  assign w_drop       = w_wr_allowed & trace_valid & w_full & ~w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_wr) r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  // Registered head: computes what the head will be after this edge so that
  // rd_data is a flop (resets to 0, holds when empty).
  always_comb begin
    w_head_load = 1'b0;
    w_head_next = w_wdata;
    if (w_empty) begin
      w_head_load = w_wr;
    end else if (w_pop) begin
      if (r_count == CNT_W'(1)) begin
        w_head_load = w_wr;
      end else begin
        w_head_load = 1'b1;
        w_head_next = r_mem[w_rd_ptr_inc];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_rd_data <= '0;
    else if (w_head_load) r_rd_data <= w_head_next;
  end

  // ---------------------------------------------------------------------------
  // Overflow status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_clear_status) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign rd_valid   = ~w_empty;
  assign rd_data    = r_rd_data;
  assign dct_count  = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign state      = r_state;

endmodule

// File: tb/tb_oci_dct_trace_capture.sv
// -----------------------------------------------------------------------------
// Testbench for oci_dct_trace_capture (DATA_W=30, DEPTH=4).
// Reference model: a word queue plus the capture state as a small integer.
// Every accepted word is pushed to a scoreboard queue; an independent monitor
// compares rd_data on each pop the DUT performs.
// -----------------------------------------------------------------------------
module tb_oci_dct_trace_capture;

  localparam int DATA_W = 30;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int TS_W   = 16;
`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int OUT_W = DATA_W + TS_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic              clk;
  logic              reset_n;
  logic              arm;
  logic              trace_valid;
  logic [DATA_W-1:0] trace_data;
  logic              test_ending;
  logic              rd_ready;
  logic              rd_valid;
  logic [OUT_W-1:0]  rd_data;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              test_has_ended;
  logic [1:0]        state;

  oci_dct_trace_capture #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .TS_W  (TS_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .trace_valid   (trace_valid),
    .trace_data    (trace_data),
    .test_ending   (test_ending),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .dct_count     (dct_count),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .test_has_ended(test_has_ended),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model (spec state encoding: 0 idle, 1 capture, 2 drain, 3 ended)
  logic [DATA_W-1:0] m_q[$];
  logic [OUT_W-1:0]  exp_q[$];
  int                m_state;
  bit                m_ovf;
  int                m_drops;
  logic [TS_W-1:0]   m_ts;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] mk_word(input logic [DATA_W-1:0] d);
`ifdef OCI_DCT_TIMESTAMP_EN
    return {m_ts, d};
`else
    return d;
`endif
  endfunction

  task automatic check_status();
    check("state",          64'(state),          64'(m_state));
    check("dct_count",      64'(dct_count),      64'(m_q.size()));
    check("rd_valid",       64'(rd_valid),       64'(m_q.size() != 0));
    check("overflow",       64'(overflow),       64'(m_ovf));
    check("drop_count",     64'(drop_count),     64'(m_drops));
    check("test_has_ended", 64'(test_has_ended), 64'(m_state == 3));
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
    m_ts    = '0;
  endtask

  // One clock: drive inputs, advance the model to the coming edge, check.
  task automatic cycle(input bit a, input bit tv, input logic [DATA_W-1:0] td,
                       input bit te, input bit rr);
    int sz;
    bit pop, wr, drp, cap;
    arm         = a;
    trace_valid = tv;
    trace_data  = td;
    test_ending = te;
    rd_ready    = rr;

    sz  = m_q.size();
    cap = (m_state == 1);
    pop = (sz > 0) && rr;
    wr  = cap && tv && ((sz < DEPTH) || pop);
    drp = cap && tv && (sz == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      m_q.push_back(td);
      exp_q.push_back(mk_word(td));
    end
    if (m_state == 3 && a) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (drp) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    case (m_state)
      0:       if (te) m_state = 2; else if (a) m_state = 1;
      1:       if (te) m_state = 2;
      2:       if (sz == 0) m_state = 3;
      default: if (a) m_state = 1;
    endcase

    @(posedge clk);
    #1;
    m_ts = m_ts + TS_W'(1);
    check_status();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    arm         = 1'b0;
    trace_valid = 1'b0;
    trace_data  = '0;
    test_ending = 1'b0;
    rd_ready    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_status();
    check("rd_data_reset", 64'(rd_data), 64'd0);
  endtask

  // Monitor: every DUT pop must present the oldest outstanding word.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_data: pop of %0h with nothing expected (t=%0t)", rd_data, $time);
        end else begin
          check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    do_reset();

    // Arm and fill three words without reading.
    cycle(1, 0, '0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, DATA_W'(i), 0, 0);
    check("head_show_ahead", 64'(rd_data), 64'(exp_q[0]));

    // 4 accepted, 5 and 6 dropped, then drain 1..4.
    for (int i = 4; i <= 6; i++) cycle(0, 1, DATA_W'(i), 0, 0);
    for (int i = 0; i < 4; i++)  cycle(0, 0, '0, 0, 1);

    // Full FIFO with simultaneous pop and write.
    for (int i = 1; i <= 4; i++) cycle(0, 1, DATA_W'(i), 0, 0);
    cycle(0, 1, DATA_W'(7), 0, 1);
    check("head_after_pop_write", 64'(rd_data), 64'(exp_q[0]));

    // Leave two queued, end test with a last write, drain and finish.
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 1, DATA_W'('hA), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0, 1);
    cycle(0, 1, DATA_W'(5), 0, 1);
    cycle(0, 1, DATA_W'(9), 1, 0);
    cycle(0, 1, DATA_W'(11), 0, 0);

    // Re-arm from ENDED clears status.
    cycle(1, 0, '0, 0, 0);

    // Asynchronous reset with entries queued.
    for (int i = 1; i <= 3; i++) cycle(0, 1, DATA_W'(i + 20), 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", 64'(dct_count), 64'd0);
    check("async_rst_valid", 64'(rd_valid),  64'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_status();

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 70,
              DATA_W'($urandom),
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 45);
      end
    end

    cycle(0, 0, '0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
